max_sequenza: RTL and testbench

//  Sequential running-maximum engine over a stream of N-bit unsigned values.

---
 rtl/max_sequenza.sv | 96 +++++++++
 tb/tb_max_sequenza.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/max_sequenza.sv
// Running-maximum engine over a stream of unsigned N-bit values, driving an external "greater than" comparator.
// Optional first-occurrence index tracking is enabled by defining MAX_SEQ_INDEX_EN.
module max_sequenza #(
  parameter int N = 2,
  parameter int C = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic [N-1:0] cmp_x,
  output logic [N-1:0] cmp_y,
  input  logic         cmp_gt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_max,
  output logic [C-1:0] out_count,
  output logic [C-1:0] out_idx
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [C-1:0] CNT_MAX = '1;

  state_t       state;
  logic [N-1:0] max_reg;
  logic [C-1:0] count;
  logic         accept;
  logic         handoff;

  assign accept    = in_valid & in_ready;
  assign handoff   = out_valid & out_ready;
  assign cmp_x     = in_data;
  assign cmp_y     = max_reg;
  assign out_max   = max_reg;
  assign out_count = count;

  // in_ready/out_valid are registered alongside the state so they always mirror it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      max_reg   <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          max_reg   <= in_data;
          count     <= C'(1);
          state     <= in_last ? DONE : ACC;
          in_ready  <= ~in_last;
          out_valid <= in_last;
        end
        ACC: if (accept) begin
          if (cmp_gt) max_reg <= in_data;
          if (count != CNT_MAX) count <= count + C'(1);
          state     <= in_last ? DONE : ACC;
          in_ready  <= ~in_last;
          out_valid <= in_last;
        end
        DONE: if (handoff) begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAX_SEQ_INDEX_EN
  logic [C-1:0] idx;

  // Strict gt keeps the first occurrence; a saturated count pins a late max at CNT_MAX.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx <= '0;
    end else if (accept) begin
      if (state == IDLE)                idx <= '0;
      else if (state == ACC && cmp_gt)  idx <= count;
    end
  end

  assign out_idx = idx;
`else
  assign out_idx = '0;
`endif

endmodule

// File: tb/tb_max_sequenza.sv
// Scoreboard bench for max_sequenza (N=2, C=4) with a behavioural comparator on the cmp_* ports.
module tb_max_sequenza;

  localparam int N = 2;
  localparam int C = 4;
  localparam int CSAT = (1 << C) - 1;

  typedef struct {
    int mx;
    int cnt;
    int idx;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         in_last = 1'b0;
  logic [N-1:0] cmp_x;
  logic [N-1:0] cmp_y;
  logic         cmp_gt;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] out_max;
  logic [C-1:0] out_count;
  logic [C-1:0] out_idx;

  int   vectors = 0;
  int   errors  = 0;
  int   seq[$];
  exp_t sb[$];

  max_sequenza #(.N(N), .C(C)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .cmp_x(cmp_x), .cmp_y(cmp_y), .cmp_gt(cmp_gt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_count(out_count), .out_idx(out_idx)
  );

  assign cmp_gt = (cmp_x > cmp_y);

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send(input int d, input bit last);
    int t = 0;
    in_valid = 1'b1;
    in_data  = N'(d);
    in_last  = last;
    while (!in_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) chk("send_timeout", 0, 1);
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_seq(input string tag, input bit gaps, input int hold);
    exp_t e;
    exp_t got;
    int   n = seq.size();
    e.mx = 0; e.cnt = 0; e.idx = 0;
    for (int i = 0; i < n; i++) begin
      if (i == 0 || seq[i] > e.mx) begin
        e.mx  = seq[i];
        e.idx = (i > CSAT) ? CSAT : i;
      end
    end
    e.cnt = (n > CSAT) ? CSAT : n;
`ifndef MAX_SEQ_INDEX_EN
    e.idx = 0;
`endif
    sb.push_back(e);

    for (int i = 0; i < n; i++) begin
      if (i == n - 1 && hold > 0) out_ready = 1'b0;
      send(seq[i], i == n - 1);
      if (i != n - 1) begin
        chk({tag, "_busy_valid"}, out_valid, 0);
        if (gaps) begin
          @(negedge clock);
          chk({tag, "_gap_ready"}, in_ready, 1);
          chk({tag, "_gap_valid"}, out_valid, 0);
        end
      end
    end

    chk({tag, "_latency"}, out_valid, 1);
    chk({tag, "_done_ready"}, in_ready, 0);
    if (out_valid) begin
      got = sb.pop_front();
      chk({tag, "_max"}, out_max, got.mx);
      chk({tag, "_count"}, out_count, got.cnt);
      chk({tag, "_idx"}, out_idx, got.idx);
    end else begin
      chk({tag, "_no_result"}, 0, 1);
      void'(sb.pop_front());
    end

    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_ready"}, in_ready, 0);
      chk({tag, "_hold_max"}, out_max, e.mx);
      chk({tag, "_hold_count"}, out_count, e.cnt);
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk({tag, "_handoff_valid"}, out_valid, 0);
    chk({tag, "_handoff_ready"}, in_ready, 1);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_max", out_max, 0);
    chk("rst_count", out_count, 0);
    chk("rst_idx", out_idx, 0);

    seq = '{1, 3, 2, 3};
    run_seq("t1", 1'b0, 0);

    seq = '{2};
    run_seq("t2", 1'b0, 0);

    seq = '{0, 1, 3, 2};
    run_seq("t3", 1'b0, 5);

    seq = '{0, 2};
    run_seq("t4", 1'b1, 0);

    seq.delete();
    for (int i = 0; i < 18; i++) seq.push_back(0);
    seq.push_back(3);
    run_seq("t5", 1'b0, 0);

    // Reset lands mid-sequence while a new element is offered.
    send(1, 1'b0);
    send(3, 1'b0);
    in_valid = 1'b1;
    in_data  = 2'd2;
    reset    = 1'b1;
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("t6_rst_ready", in_ready, 1);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_count", out_count, 0);
    chk("t6_rst_max", out_max, 0);
    seq = '{1};
    run_seq("t6", 1'b0, 0);

    seq = '{3, 1, 3, 2, 0};
    run_seq("t7", 1'b1, 2);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
